sdrd_deser: RTL



---
 rtl/sdrd_pkg.sv | 14 +
 rtl/sdrd_gap_timer.sv | 39 +++
 rtl/sdrd_deser.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sdrd_pkg.sv
// Shared types and constants for the SDRD serial-read deserializer.
package sdrd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } sdrd_state_e;

  localparam int NBITS_DEF   = 8;
  localparam int GAP_MAX_DEF = 1000;
  localparam int GAP_W       = 16;

endpackage

// File: rtl/sdrd_gap_timer.sv
// Inter-strobe gap counter: clears on reload or when disabled, otherwise counts up and saturates.
module sdrd_gap_timer
  import sdrd_pkg::*;
#(
  parameter int GAP_MAX = GAP_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic reload,
  output logic expire
);

  localparam logic [GAP_W-1:0] LIMIT = GAP_W'(GAP_MAX - 1);

  logic [GAP_W-1:0] count_q;
  logic [GAP_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!en || reload) begin
      count_d = '0;
    end else if (count_q != '1) begin
      count_d = count_q + 1'b1;
    end
  end

  // Fires in the cycle whose increment would bring the count to GAP_MAX.
  assign expire = en && !reload && (count_q == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sdrd_deser.sv
// Deserializes qualified SDRD serial-read bits into an NBITS word, LSB first,
// with frame sync, consumer handshake and sticky overrun/gap error flags.
module sdrd_deser
  import sdrd_pkg::*;
#(
  parameter int NBITS   = NBITS_DEF,
  parameter int GAP_MAX = GAP_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_sync,
  input  logic             bit_stb,
  input  logic             sdrd,
  input  logic             data_ack,
  input  logic             err_clr,
  output logic [NBITS-1:0] data_out,
  output logic             data_vld,
  output logic             busy,
  output logic             overrun,
  output logic             gap_err
);

  localparam int               CW   = $clog2(NBITS + 1);
  localparam logic [CW-1:0]    LAST = CW'(NBITS - 1);

  sdrd_state_e      state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic             gerr_q, gerr_d;
  logic             ovr_set, gerr_set;
  logic             gap_expire;

  sdrd_gap_timer #(
    .GAP_MAX (GAP_MAX)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q == SHIFT),
    .reload (frame_sync || bit_stb),
    .expire (gap_expire)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    vld_d     = vld_q;
    ovr_set   = 1'b0;
    gerr_set  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (frame_sync) begin
          bit_cnt_d = '0;
          data_d    = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (frame_sync) begin
          bit_cnt_d = '0;
          data_d    = '0;
        end else if (bit_stb) begin
          data_d    = {sdrd, data_q[NBITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST) begin
            state_d = FULL;
            vld_d   = 1'b1;
          end
        end else if (gap_expire) begin
          gerr_set = 1'b1;
          state_d  = IDLE;
        end
      end
      FULL: begin
        // An ack absorbs any same-cycle strobe or sync, so no overrun then.
        if (data_ack) begin
          vld_d = 1'b0;
          if (frame_sync) begin
            bit_cnt_d = '0;
            data_d    = '0;
            state_d   = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end else if (bit_stb || frame_sync) begin
          ovr_set = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ovr_d  = ovr_set  || (ovr_q  && !err_clr);
    gerr_d = gerr_set || (gerr_q && !err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      ovr_q     <= 1'b0;
      gerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      ovr_q     <= ovr_d;
      gerr_q    <= gerr_d;
    end
  end

  assign data_out = data_q;
  assign data_vld = vld_q;
  assign busy     = (state_q == SHIFT);
  assign overrun  = ovr_q;
  assign gap_err  = gerr_q;

endmodule
